letreiro_scan_controller: RTL and testbench
===========================================

// Module: letreiro_scan_controller
// PURPOSE
// - Sequences the 5x7 LED-matrix sign. Time-multiplexes the rows with a dead-time gap between rows to stop ghosting.
// - Generates the frame-aligned step pulse for the per-row pattern shift registers, replacing the free-running divider.
// - Decodes the ch0/ch1 switches into pause / scroll-left / scroll-right / reload-and-blank.
// - Sits between the row shift registers (input: frame_data; outputs: shift_en, shift_dir, load) and the matrix pins (L, C).
// PARAMETERS
// ROWS             5     matrix rows (L lines)
// COLS             7     matrix columns (C lines)
// ROW_CYCLES       1000  CLK cycles one row is driven; >=1
// BLANK_CYCLES     16    CLK cycles all lines off before each row; 0 = no gap
// FRAMES_PER_STEP  10    full frames between shift_en pulses; >=1
// COL_ACTIVE_LOW   1     1: C bit low = LED on; 0: high = on (L is always active-high)
// PORTS
// CLK          in   1          system clock, all state on rising edge
// RST          in   1          asynchronous, active-high reset
// ch0          in   1          mode switch bit 0, asynchronous to CLK
// ch1          in   1          mode switch bit 1, asynchronous to CLK
// frame_data   in   ROWS*COLS  pattern; row r = [r*COLS +: COLS], bit c = column c+1, 1 = lit
// L            out  ROWS       row drive, one-hot when driving, else all 0
// C            out  COLS       column drive, polarity per COL_ACTIVE_LOW
// shift_en     out  1          1-cycle pulse: shift registers advance one position
// shift_dir    out  1          0 = left, 1 = right; valid whenever shift_en=1
// load         out  1          1-cycle pulse: shift registers reload preset pattern
// frame_start  out  1          1-cycle pulse on entry to row 0 blank phase
// BEHAVIOUR
// - Reset (async, immediate, also mid-frame): L=0, C=all-off, shift_en=0, shift_dir=0, load=0, frame_start=0.
//   Internal reset state: state=BLANK, row=0, cycle and frame counters=0, mode=PAUSE, synchroniser flops=0.
// - ch0/ch1 pass through a 2-flop synchroniser. Synced value {ch1,ch0} is latched into mode only at a frame boundary.
//   Frame boundary = the edge where row ROWS-1 leaves DRIVE. Mid-frame switch changes have no effect.
// - Modes: 00 PAUSE, 01 LEFT, 10 RIGHT, 11 LOAD.
// - Scan FSM states: BLANK, DRIVE; all outputs registered, updated on the same edge as the state change.
//   BLANK: L=0, C=all-off for BLANK_CYCLES cycles, then DRIVE. BLANK_CYCLES=0 -> BLANK takes zero cycles, goes straight to DRIVE.
//   DRIVE: L[row]=1; C = frame_data row slice, captured on the entry edge and held ROWS_CYCLES... see next line.
//   C stays constant for all ROW_CYCLES cycles of DRIVE. On exit, row increments; ROWS-1 wraps to 0.
// - Whole frame = ROWS*(ROW_CYCLES+BLANK_CYCLES) cycles.
// - frame_start=1 for 1 cycle on the edge entering row 0 (BLANK, or DRIVE if BLANK_CYCLES=0), including the first entry after reset.
// - Frame counter counts frame boundaries 0..FRAMES_PER_STEP-1 and wraps; it keeps running in every mode.
//   On wrap with the newly latched mode LEFT/RIGHT: shift_en=1 for one cycle, coincident with frame_start; shift_dir=0/1 respectively.
//   shift_dir holds its last value otherwise.
// - PAUSE: scan continues, shift_en never asserted.
// - LOAD: load=1 for one cycle at the first frame boundary where mode becomes 11, regardless of the frame counter.
//   Not re-pulsed while mode stays 11. While mode=11, L forced to 0 (display blank) but the FSM keeps running.
// - Invariants: shift_en and load never high together; L never has more than one bit set; L=0 whenever state=BLANK.
// - Counter widths: $clog2 of terminal value, minimum 1 bit; compare against terminal-1, no overflow past terminal.
// STRUCTURE
// - Package letreiro_pkg: mode_t {MODE_PAUSE=2'b00, MODE_LEFT=2'b01, MODE_RIGHT=2'b10, MODE_LOAD=2'b11}.
//   Package also holds scan_state_t {ST_BLANK, ST_DRIVE} and default LETREIRO_ROWS=5, LETREIRO_COLS=7.
// - Sub-module sincronizador_2ff (1-bit, async reset to 0), instantiated twice, once for ch0 and once for ch1.
// - Rest in one module: scan FSM, row counter, cycle counter, frame counter, mode latch, output registers.
// TESTING (ROW_CYCLES=4, BLANK_CYCLES=2, FRAMES_PER_STEP=3, COL_ACTIVE_LOW=1; frame = 30 cycles)
// 1 Reset release, ch=00, row0 data=7'b1010101 -> frame_start at cycle 1; L=00000, C=1111111 for 2 cycles;
//   then L=00001, C=0101010 for 4 cycles; L walks 00010..10000; frame repeats every 30 cycles.
// 2 ch=01 held -> mode LEFT from first boundary; shift_en pulses every 90 cycles with shift_dir=0, each with frame_start; load stays 0.
// 3 ch 01->10 mid-frame -> next pulse still left only if at that boundary; after boundary, pulses have shift_dir=1.
//   No glitch pulse at the switch instant.
// 4 ch=11 -> exactly one load pulse at the next boundary; L stays 00000 while 11 held; shift_en=0.
//   Back to 00 -> display resumes at the next boundary.
// 5 Assert RST in DRIVE of row 2 -> same-cycle L=0, C=all-off, pulses 0; after release the scan restarts at row 0 with frame_start.
// 6 BLANK_CYCLES=0 build -> L never 0 between rows; frame = 20 cycles; frame_start coincides with L=00001.

Source files
------------

// File: rtl/letreiro_pkg.sv
// Shared types and defaults for the LED-matrix sign scan controller.
// Contents:
//   mode_t       - decoded {ch1,ch0} switch modes
//   scan_state_t - row scan FSM states
//   LETREIRO_*   - default matrix geometry
//   cnt_width()  - counter width for a terminal count, never below 1 bit
package letreiro_pkg;

  typedef enum logic [1:0] {
    MODE_PAUSE = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  localparam int LETREIRO_ROWS = 5;
  localparam int LETREIRO_COLS = 7;

  function automatic int cnt_width(input int terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for one asynchronous level input.
// Ports:
//   CLK     - destination clock
//   RST     - asynchronous active-high reset, clears both flops
//   i_async - asynchronous input level
//   o_sync  - synchronised level, two CLK edges of latency
module sincronizador_2ff
  import letreiro_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge value of its source, whatever the statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/letreiro_scan_controller.sv
// Scan controller for the 5x7 LED-matrix sign.
// Scans the rows one at a time with an all-off gap before each row, latches
// the ch0/ch1 mode at frame boundaries and issues frame-aligned shift/load
// pulses to the row pattern shift registers.
// Ports:
//   CLK, RST          - clock, asynchronous active-high reset
//   ch0, ch1          - asynchronous mode switches ({ch1,ch0}: pause/left/right/load)
//   frame_data        - pattern, row r = [r*COLS +: COLS], 1 = lit
//   L                 - row drive, one-hot or zero
//   C                 - column drive, polarity set by COL_ACTIVE_LOW
//   shift_en/shift_dir- one-cycle advance pulse and its direction (1 = right)
//   load              - one-cycle reload pulse
//   frame_start       - one-cycle pulse on entry to row 0
module letreiro_scan_controller
  import letreiro_pkg::*;
#(
  parameter int ROWS            = LETREIRO_ROWS,
  parameter int COLS            = LETREIRO_COLS,
  parameter int ROW_CYCLES      = 1000,
  parameter int BLANK_CYCLES    = 16,
  parameter int FRAMES_PER_STEP = 10,
  parameter int COL_ACTIVE_LOW  = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ch0,
  input  logic                 ch1,
  input  logic [ROWS*COLS-1:0] frame_data,
  output logic [ROWS-1:0]      L,
  output logic [COLS-1:0]      C,
  output logic                 shift_en,
  output logic                 shift_dir,
  output logic                 load,
  output logic                 frame_start
);

  localparam int CYC_W = cnt_width((ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES);
  localparam int ROW_W = cnt_width(ROWS);
  localparam int FRM_W = cnt_width(FRAMES_PER_STEP);

  localparam logic [CYC_W-1:0] ROW_LAST   = CYC_W'(ROW_CYCLES - 1);
  localparam logic [CYC_W-1:0] BLANK_LAST = CYC_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [ROW_W-1:0] ROW_MAX    = ROW_W'(ROWS - 1);
  localparam logic [FRM_W-1:0] FRM_MAX    = FRM_W'(FRAMES_PER_STEP - 1);
  // All-off column word; XOR with it turns a lit-pattern into pin levels.
  localparam logic [COLS-1:0]  C_OFF      = (COL_ACTIVE_LOW != 0) ? {COLS{1'b1}} : {COLS{1'b0}};

  logic w_ch0_sync;
  logic w_ch1_sync;

  sincronizador_2ff u_sync_ch0 (.CLK(CLK), .RST(RST), .i_async(ch0), .o_sync(w_ch0_sync));
  sincronizador_2ff u_sync_ch1 (.CLK(CLK), .RST(RST), .i_async(ch1), .o_sync(w_ch1_sync));

  scan_state_t      r_state,  w_state_nxt;
  logic [ROW_W-1:0] r_row,    w_row_nxt;
  logic [CYC_W-1:0] r_cycle,  w_cycle_nxt;
  logic [FRM_W-1:0] r_frame,  w_frame_nxt;
  mode_t            r_mode,   w_mode_nxt;
  // Low only until the first edge after reset, which counts as entering row 0.
  logic             r_run;
  logic [ROWS-1:0]  r_l,      w_l_nxt;
  logic [COLS-1:0]  r_c,      w_c_nxt;
  logic             r_shift_en, w_shift_en_nxt;
  logic             r_shift_dir, w_shift_dir_nxt;
  logic             r_load,   w_load_nxt;
  logic             r_fs,     w_fs_nxt;

  logic             w_enter;      // entering the (optional) blank phase of a row
  logic [ROW_W-1:0] w_enter_row;
  logic             w_drive_go;   // entering DRIVE of w_row_nxt
  logic             w_wrap;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    w_state_nxt     = r_state;
    w_row_nxt       = r_row;
    w_cycle_nxt     = r_cycle;
    w_frame_nxt     = r_frame;
    w_mode_nxt      = r_mode;
    w_l_nxt         = r_l;
    w_c_nxt         = r_c;
    w_shift_en_nxt  = 1'b0;
    w_shift_dir_nxt = r_shift_dir;
    w_load_nxt      = 1'b0;
    w_fs_nxt        = 1'b0;
    w_enter         = 1'b0;
    w_enter_row     = r_row;
    w_drive_go      = 1'b0;
    w_wrap          = 1'b0;

    if (!r_run) begin
      w_enter     = 1'b1;
      w_enter_row = '0;
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (r_cycle == BLANK_LAST) w_drive_go  = 1'b1;
          else                       w_cycle_nxt = r_cycle + 1'b1;
        end
        ST_DRIVE: begin
          if (r_cycle == ROW_LAST) begin
            w_enter     = 1'b1;
            w_enter_row = (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
            if (r_row == ROW_MAX) begin
              // Frame boundary: the only place mode and frame count change.
              w_mode_nxt  = mode_t'({w_ch1_sync, w_ch0_sync});
              w_wrap      = (r_frame == FRM_MAX);
              w_frame_nxt = w_wrap ? '0 : r_frame + 1'b1;
              if (w_wrap && (w_mode_nxt == MODE_LEFT || w_mode_nxt == MODE_RIGHT)) begin
                w_shift_en_nxt  = 1'b1;
                w_shift_dir_nxt = (w_mode_nxt == MODE_RIGHT);
              end
              w_load_nxt = (w_mode_nxt == MODE_LOAD) && (r_mode != MODE_LOAD);
            end
          end else begin
            w_cycle_nxt = r_cycle + 1'b1;
          end
        end
        default: w_state_nxt = ST_BLANK;
      endcase
    end

    if (w_enter) begin
      w_row_nxt   = w_enter_row;
      w_cycle_nxt = '0;
      w_fs_nxt    = (w_enter_row == '0);
      if (BLANK_CYCLES == 0) begin
        w_drive_go = 1'b1;
      end else begin
        w_state_nxt = ST_BLANK;
        w_l_nxt     = '0;
        w_c_nxt     = C_OFF;
      end
    end

    if (w_drive_go) begin
      w_state_nxt = ST_DRIVE;
      w_cycle_nxt = '0;
      w_l_nxt     = (w_mode_nxt == MODE_LOAD) ? '0 : ROWS'(1) << w_row_nxt;
      w_c_nxt     = frame_data[int'(w_row_nxt)*COLS +: COLS] ^ C_OFF;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_BLANK;
      r_row       <= '0;
      r_cycle     <= '0;
      r_frame     <= '0;
      r_mode      <= MODE_PAUSE;
      r_run       <= 1'b0;
      r_l         <= '0;
      r_c         <= C_OFF;
      r_shift_en  <= 1'b0;
      r_shift_dir <= 1'b0;
      r_load      <= 1'b0;
      r_fs        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_cycle     <= w_cycle_nxt;
      r_frame     <= w_frame_nxt;
      r_mode      <= w_mode_nxt;
      r_run       <= 1'b1;
      r_l         <= w_l_nxt;
      r_c         <= w_c_nxt;
      r_shift_en  <= w_shift_en_nxt;
      r_shift_dir <= w_shift_dir_nxt;
      r_load      <= w_load_nxt;
      r_fs        <= w_fs_nxt;
    end
  end

  assign L           = r_l;
  assign C           = r_c;
  assign shift_en    = r_shift_en;
  assign shift_dir   = r_shift_dir;
  assign load        = r_load;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_letreiro_scan_controller.sv
// Self-checking bench for letreiro_scan_controller.
// Two builds run side by side on shared inputs: dut0 with a 2-cycle blank gap
// and dut1 with no gap. A reference model derives every expected output from
// the cycle count since reset, the frame geometry and the switch history.
module tb_letreiro_scan_controller;
  import letreiro_pkg::*;

  localparam int ROWS = 5;
  localparam int COLS = 7;
  localparam int RC   = 4;
  localparam int FPS  = 3;
  localparam int NB   = ROWS * COLS;
  localparam int VW   = ROWS + COLS + 4;
  localparam logic [VW-1:0] RESET_V = {{ROWS{1'b0}}, {COLS{1'b1}}, 4'b0000};

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          ch0 = 1'b0;
  logic          ch1 = 1'b0;
  logic [NB-1:0] frame_data = '0;

  logic [ROWS-1:0] l_a, l_b;
  logic [COLS-1:0] c_a, c_b;
  logic se_a, sd_a, ld_a, fs_a;
  logic se_b, sd_b, ld_b, fs_b;

  always #5 CLK = ~CLK;

  letreiro_scan_controller #(
    .ROWS(ROWS), .COLS(COLS), .ROW_CYCLES(RC), .BLANK_CYCLES(2),
    .FRAMES_PER_STEP(FPS), .COL_ACTIVE_LOW(1)
  ) dut0 (
    .CLK(CLK), .RST(RST), .ch0(ch0), .ch1(ch1), .frame_data(frame_data),
    .L(l_a), .C(c_a), .shift_en(se_a), .shift_dir(sd_a), .load(ld_a), .frame_start(fs_a)
  );

  letreiro_scan_controller #(
    .ROWS(ROWS), .COLS(COLS), .ROW_CYCLES(RC), .BLANK_CYCLES(0),
    .FRAMES_PER_STEP(FPS), .COL_ACTIVE_LOW(1)
  ) dut1 (
    .CLK(CLK), .RST(RST), .ch0(ch0), .ch1(ch1), .frame_data(frame_data),
    .L(l_b), .C(c_b), .shift_en(se_b), .shift_dir(sd_b), .load(ld_b), .frame_start(fs_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int              t;           // rising edges since reset release
  logic [1:0]      ch_hist[$];  // {ch1,ch0} as seen at each edge
  int              m_bound[2];
  mode_t           m_mode[2];
  logic            m_dir[2];
  logic [COLS-1:0] m_cap[2];
  logic [VW-1:0]   exp_v[2];
  logic [VW-1:0]   act_v[2];

  task automatic model_reset();
    t = 0;
    ch_hist.delete();
    for (int d = 0; d < 2; d++) begin
      m_bound[d] = 0;
      m_mode[d]  = MODE_PAUSE;
      m_dir[d]   = 1'b0;
      m_cap[d]   = '0;
    end
  endtask

  task automatic sample();
    act_v[0] = {l_a, c_a, se_a, sd_a, ld_a, fs_a};
    act_v[1] = {l_b, c_b, se_b, sd_b, ld_b, fs_b};
  endtask

  // Expected outputs after edge t for the build with blank gap bc.
  task automatic model_eval(input int d);
    int bc, per, fl, p, row, w;
    logic drive, sh, ld, fs;
    mode_t prev;
    logic [ROWS-1:0] l_exp;
    logic [COLS-1:0] c_exp;
    bc  = (d == 0) ? 2 : 0;
    per = RC + bc;
    fl  = ROWS * per;
    p   = (t - 1) % fl;
    row = p / per;
    w   = p % per;
    drive = (w >= bc);
    fs = (p == 0);
    sh = 1'b0;
    ld = 1'b0;
    if (p == 0 && t > 1) begin
      m_bound[d]++;
      prev = m_mode[d];
      m_mode[d] = mode_t'(ch_hist[ch_hist.size() - 3]);  // two-flop delay
      if ((m_bound[d] % FPS) == 0 && (m_mode[d] == MODE_LEFT || m_mode[d] == MODE_RIGHT)) begin
        sh = 1'b1;
        m_dir[d] = (m_mode[d] == MODE_RIGHT);
      end
      ld = (m_mode[d] == MODE_LOAD) && (prev != MODE_LOAD);
    end
    if (drive && w == bc) m_cap[d] = frame_data[row*COLS +: COLS];
    l_exp = (drive && m_mode[d] != MODE_LOAD) ? ROWS'(1) << row : '0;
    c_exp = drive ? ~m_cap[d] : {COLS{1'b1}};
    exp_v[d] = {l_exp, c_exp, sh, m_dir[d], ld, fs};
  endtask

  // One clock: record switch level at the edge, evaluate model, sample DUTs,
  // then optionally change the pattern mid-cycle.
  task automatic step_cycle(input bit rnd_data);
    @(posedge CLK);
    t++;
    ch_hist.push_back({ch1, ch0});
    #1;
    model_eval(0);
    model_eval(1);
    sample();
    if (rnd_data && $urandom_range(0, 3) == 0) frame_data = NB'({$urandom(), $urandom()});
  endtask

  task automatic test_reset();
    #1 RST = 1'b1;
    #10;
    sample();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (act_v[d] !== RESET_V) begin
        miscompares++;
        $display("FAIL reset dut%0d {L,C,se,sd,ld,fs} got %b expected %b", d, act_v[d], RESET_V);
      end
    end
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_scan_pause();
    {ch1, ch0} = 2'b00;
    for (int i = 0; i < 75; i++) begin
      step_cycle(i >= 60);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (act_v[d] !== exp_v[d]) begin
          miscompares++;
          $display("FAIL scan_pause dut%0d t=%0d {L,C,se,sd,ld,fs} got %b expected %b", d, t, act_v[d], exp_v[d]);
        end
      end
    end
  endtask

  task automatic test_scroll_left();
    {ch1, ch0} = 2'b01;
    for (int i = 0; i < 210; i++) begin
      step_cycle(1'b1);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (act_v[d] !== exp_v[d]) begin
          miscompares++;
          $display("FAIL scroll_left dut%0d t=%0d {L,C,se,sd,ld,fs} got %b expected %b", d, t, act_v[d], exp_v[d]);
        end
      end
    end
  endtask

  task automatic test_dir_switch();
    int n;
    n = 0;
    // Move to mid-frame of dut0 before flipping the switches.
    while (((t - 1) % 30) != 10 && n < 40) begin
      step_cycle(1'b0);
      n++;
    end
    {ch1, ch0} = 2'b10;
    for (int i = 0; i < 200; i++) begin
      step_cycle(1'b1);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (act_v[d] !== exp_v[d]) begin
          miscompares++;
          $display("FAIL dir_switch dut%0d t=%0d {L,C,se,sd,ld,fs} got %b expected %b", d, t, act_v[d], exp_v[d]);
        end
      end
    end
  endtask

  task automatic test_load();
    int loads;
    loads = 0;
    {ch1, ch0} = 2'b11;
    for (int i = 0; i < 120; i++) begin
      step_cycle(1'b1);
      loads += int'(ld_a);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (act_v[d] !== exp_v[d]) begin
          miscompares++;
          $display("FAIL load_hold dut%0d t=%0d {L,C,se,sd,ld,fs} got %b expected %b", d, t, act_v[d], exp_v[d]);
        end
      end
    end
    vectors++;
    if (loads != 1) begin
      miscompares++;
      $display("FAIL load_count got %0d pulses expected 1", loads);
    end
    {ch1, ch0} = 2'b00;
    for (int i = 0; i < 70; i++) begin
      step_cycle(1'b1);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (act_v[d] !== exp_v[d]) begin
          miscompares++;
          $display("FAIL load_resume dut%0d t=%0d {L,C,se,sd,ld,fs} got %b expected %b", d, t, act_v[d], exp_v[d]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_drive();
    int n;
    n = 0;
    // Row 2 DRIVE of dut0 occupies frame positions 14..17.
    while (((t - 1) % 30) != 15 && n < 40) begin
      step_cycle(1'b0);
      n++;
    end
    vectors++;
    if (l_a !== 5'b00100) begin
      miscompares++;
      $display("FAIL reset_pre_row2 L got %b expected %b", l_a, 5'b00100);
    end
    #2 RST = 1'b1;
    #1;
    sample();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (act_v[d] !== RESET_V) begin
        miscompares++;
        $display("FAIL reset_mid_drive dut%0d {L,C,se,sd,ld,fs} got %b expected %b", d, act_v[d], RESET_V);
      end
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    for (int i = 0; i < 70; i++) begin
      step_cycle(1'b1);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (act_v[d] !== exp_v[d]) begin
          miscompares++;
          $display("FAIL reset_restart dut%0d t=%0d {L,C,se,sd,ld,fs} got %b expected %b", d, t, act_v[d], exp_v[d]);
        end
      end
    end
  endtask

  task automatic test_random_modes();
    int len;
    for (int k = 0; k < 25; k++) begin
      {ch1, ch0} = 2'($urandom_range(0, 3));
      len = int'($urandom_range(5, 70));
      for (int i = 0; i < len; i++) begin
        step_cycle(1'b1);
        for (int d = 0; d < 2; d++) begin
          vectors++;
          if (act_v[d] !== exp_v[d]) begin
            miscompares++;
            $display("FAIL random_modes dut%0d t=%0d {L,C,se,sd,ld,fs} got %b expected %b", d, t, act_v[d], exp_v[d]);
          end
        end
      end
    end
  endtask

  initial begin
    frame_data = NB'({$urandom(), $urandom()});
    frame_data[0 +: COLS] = 7'b1010101;
    model_reset();
    test_reset();
    test_scan_pause();
    test_scroll_left();
    test_dir_switch();
    test_load();
    test_reset_mid_drive();
    test_random_modes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
